// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM-subset control unit.
// A Moore main FSM sequences fetch, decode, execute, memory access and
// writeback over 3-5 cycles. It supports a memory-ready handshake on the
// shared instruction/data memory, and keeps registered NZCV flags for
// conditional execution.
//
// Ports
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   Instr[31:12]      current IR contents
//   ALUFlags          NZCV produced by the ALU this cycle
//   MemReady          memory access completes this cycle
//   PCWrite, IRWrite, MemWrite, RegWrite   write enables (0 while reset)
//   AdrSrc            memory address select: 0 = PC, 1 = ALUResult register
//   ByteMem           byte-wide memory access (LDRB/STRB)
//   ResultSrc         00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA           00 = Rn, 01 = PC, 10 = ALUOut
//   ALUSrcB           00 = Rm, 01 = ExtImm, 10 = constant 4
//   ImmSrc, RegSrc    immediate extend type and register address selects
//   ALUControl        ALU operation; bits above [2] are always 0
//   State             current FSM state encoding, for debug
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE | read registers, form PC+8, latch condition result
// MEMADR | compute load/store address (Rn +/- imm)
// MEMRD  | read data memory, wait for ready
// MEMWB  | write loaded data to Rd
// MEMWR  | write data memory, wait for ready
// EXECR  | data processing with register operand
// EXECI  | data processing with immediate operand
// ALUWB  | write ALU result to Rd (or PC when Rd is R15)
// BRANCH | PC <= PC+8+offset
module mc_controller #(
    parameter int ALUCTRL_W     = 3,
    parameter int BYTE_EN       = 1,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:12]         Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 ByteMem,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t     state;
    logic [3:0] flags;      // N Z C V
    logic       cond_ex;

    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit;
    logic [3:0] cmd;
    logic       u_bit;
    logic       b_bit;
    logic       l_bit;
    logic [3:0] rd;
    logic       ready;
    logic       cond_pass;
    logic [2:0] dp_alu;
    logic       cmd_ok;
    logic       is_cmp;
    logic       cv_upd;
    logic       dp_we;
    logic [2:0] alu_op;
    logic       unused_rn;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign i_bit = Instr[25];
    assign cmd   = Instr[24:21];
    assign u_bit = Instr[23];
    assign b_bit = Instr[22];
    assign l_bit = Instr[20];    // also the S bit for data processing
    assign rd    = Instr[15:12];
    assign unused_rn = ^Instr[19:16];

    assign ready = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'h0: cond_pass = flags[2];
            4'h1: cond_pass = ~flags[2];
            4'h2: cond_pass = flags[1];
            4'h3: cond_pass = ~flags[1];
            4'h4: cond_pass = flags[3];
            4'h5: cond_pass = ~flags[3];
            4'h6: cond_pass = flags[0];
            4'h7: cond_pass = ~flags[0];
            4'h8: cond_pass = flags[1] & ~flags[2];
            4'h9: cond_pass = ~flags[1] | flags[2];
            4'hA: cond_pass = (flags[3] == flags[0]);
            4'hB: cond_pass = (flags[3] != flags[0]);
            4'hC: cond_pass = ~flags[2] & (flags[3] == flags[0]);
            4'hD: cond_pass = flags[2] | (flags[3] != flags[0]);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        dp_alu = 3'b000;
        cmd_ok = 1'b1;
        case (cmd)
            4'b0100: dp_alu = 3'b000;
            4'b0010: dp_alu = 3'b001;
            4'b0000: dp_alu = 3'b010;
            4'b1100: dp_alu = 3'b011;
            4'b0001: dp_alu = 3'b100;
            4'b1101: dp_alu = 3'b101;
            4'b1010: dp_alu = 3'b001;
            default: cmd_ok = 1'b0;
        endcase
    end

    assign is_cmp = (cmd == 4'b1010);
    assign cv_upd = (cmd == 4'b0100) | (cmd == 4'b0010) | is_cmp;
    assign dp_we  = cond_ex & cmd_ok & ~is_cmp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            flags   <= 4'b0000;
            cond_ex <= 1'b0;
        end else begin
            case (state)
                FETCH:  if (ready) state <= DECODE;
                DECODE: begin
                    cond_ex <= cond_pass;
                    case (op)
                        2'b01:   state <= MEMADR;
                        2'b00:   state <= i_bit ? EXECI : EXECR;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR: state <= l_bit ? MEMRD : MEMWR;
                MEMRD:  if (ready) state <= MEMWB;
                MEMWB:  state <= FETCH;
                // A store whose condition failed never touches memory, so
                // there is nothing to wait for.
                MEMWR:  if (!cond_ex || ready) state <= FETCH;
                EXECR, EXECI: begin
                    state <= ALUWB;
                    if (cond_ex && (l_bit || is_cmp)) begin
                        flags[3:2] <= ALUFlags[3:2];
                        if (cv_upd) flags[1:0] <= ALUFlags[1:0];
                    end
                end
                ALUWB:   state <= FETCH;
                BRANCH:  state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = 3'b000;
        case (state)
            FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = ready;
                PCWrite   = ready;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                alu_op  = u_bit ? 3'b000 : 3'b001;
            end
            MEMRD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
            end
            EXECR: alu_op = dp_alu;
            EXECI: begin
                ALUSrcB = 2'b01;
                alu_op  = dp_alu;
            end
            ALUWB: begin
                // A write to R15 is steered to the PC instead of the regfile.
                if (dp_we && rd == 4'hF) PCWrite = 1'b1;
                else                     RegWrite = dp_we;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
            end
            default: ;
        endcase
        // Reset is asynchronous, so gate enables combinationally to kill any
        // write in the cycle reset arrives.
        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    always_comb begin
        ALUControl      = '0;
        ALUControl[2:0] = alu_op;
    end

    assign ImmSrc  = op;
    assign RegSrc  = {(op == 2'b01) & ~l_bit, (op == 2'b10)};
    assign ByteMem = (BYTE_EN != 0) && (op == 2'b01) && b_bit &&
                     (state == MEMADR || state == MEMRD ||
                      state == MEMWB  || state == MEMWR);
    assign State   = state;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:12]  Instr;
    logic [3:0]    ALUFlags;
    logic          MemReady;
    logic          PCWrite, AdrSrc, IRWrite, MemWrite, ByteMem, RegWrite;
    logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0]    ALUControl;
    logic [3:0]    State;

    mc_controller #(.ALUCTRL_W(3), .BYTE_EN(1), .MEM_HANDSHAKE(1)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .ByteMem(ByteMem),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .ALUControl(ALUControl), .State(State)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic run_cmp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // {supported, alu code}
    function automatic logic [3:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 4'b1000;
            4'b0010: return 4'b1001;
            4'b0000: return 4'b1010;
            4'b1100: return 4'b1011;
            4'b0001: return 4'b1100;
            4'b1101: return 4'b1101;
            4'b1010: return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    // Sequence of states visited after DECODE, first step in the low nibble;
    // a zero nibble means back to FETCH.
    function automatic logic [15:0] plan_for(input logic [31:12] ins);
        case (ins[27:26])
            2'b01:   return ins[20] ? 16'h0432 : 16'h0052;
            2'b00:   return ins[25] ? 16'h0087 : 16'h0086;
            2'b10:   return 16'h0009;
            default: return 16'h0000;
        endcase
    endfunction

    logic [3:0]  m_state;
    logic [15:0] m_plan;
    logic [3:0]  m_flags;
    logic        m_cond;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= 4'd0;
            m_plan  <= 16'h0;
            m_flags <= 4'h0;
            m_cond  <= 1'b0;
        end else if (m_state == 4'd0) begin
            if (MemReady) m_state <= 4'd1;
        end else if (m_state == 4'd1) begin
            m_cond  <= cond_true(Instr[31:28], m_flags);
            m_state <= 4'(plan_for(Instr));
            m_plan  <= plan_for(Instr) >> 4;
        end else if ((m_state == 4'd3 && !MemReady) ||
                     (m_state == 4'd5 && m_cond && !MemReady)) begin
            m_state <= m_state;
        end else begin
            if ((m_state == 4'd6 || m_state == 4'd7) && m_cond &&
                (Instr[20] || Instr[24:21] == 4'b1010)) begin
                m_flags[3:2] <= ALUFlags[3:2];
                if (Instr[24:21] == 4'b0100 || Instr[24:21] == 4'b0010 ||
                    Instr[24:21] == 4'b1010)
                    m_flags[1:0] <= ALUFlags[1:0];
            end
            m_state <= m_plan[3:0];
            m_plan  <= m_plan >> 4;
        end
    end

    // ---------------- compare process ----------------
    logic       e_pc, e_ir, e_mw, e_rw, e_adr, e_we;
    logic [1:0] e_a, e_b, e_rs;
    logic [2:0] e_alu;
    logic       ck_adr, ck_mux, ck_rs;
    logic [3:0] e_dp;

    always @(negedge clk) begin
        #2;
        if (run_cmp) begin
            {e_pc, e_ir, e_mw, e_rw, e_adr} = '0;
            {ck_adr, ck_mux, ck_rs} = '0;
            e_a = 2'b00; e_b = 2'b00; e_rs = 2'b00; e_alu = 3'b000;
            e_dp = alu_of(Instr[24:21]);
            case (m_state)
                4'd0: begin
                    e_ir = MemReady; e_pc = MemReady;
                    ck_adr = 1; ck_mux = 1; e_a = 2'b01; e_b = 2'b10;
                    ck_rs = 1; e_rs = 2'b10;
                end
                4'd1: begin
                    ck_mux = 1; e_a = 2'b01; e_b = 2'b10; ck_rs = 1; e_rs = 2'b10;
                end
                4'd2: begin
                    ck_mux = 1; e_b = 2'b01; e_alu = Instr[23] ? 3'b000 : 3'b001;
                end
                4'd3: begin ck_adr = 1; e_adr = 1; end
                4'd4: begin ck_rs = 1; e_rs = 2'b01; e_rw = m_cond; end
                4'd5: begin ck_adr = 1; e_adr = 1; e_mw = m_cond; end
                4'd6, 4'd7: begin
                    ck_mux = 1; e_b = (m_state == 4'd7) ? 2'b01 : 2'b00;
                    e_alu = e_dp[2:0];
                end
                4'd8: begin
                    ck_rs = 1;
                    e_we = m_cond && e_dp[3] && (Instr[24:21] != 4'b1010);
                    if (e_we && Instr[15:12] == 4'hF) e_pc = 1;
                    else e_rw = e_we;
                end
                4'd9: begin
                    ck_mux = 1; e_b = 2'b01; ck_rs = 1; e_rs = 2'b10; e_pc = m_cond;
                end
                default: ;
            endcase
            if (reset) {e_pc, e_ir, e_mw, e_rw} = '0;
            chk("m_state", 32'(State), 32'(m_state));
            chk("m_enables", 32'({PCWrite, IRWrite, MemWrite, RegWrite}),
                32'({e_pc, e_ir, e_mw, e_rw}));
            chk("m_flags", 32'(dut.flags), 32'(m_flags));
            chk("m_immsrc", 32'(ImmSrc), 32'(Instr[27:26]));
            chk("m_regsrc", 32'(RegSrc),
                32'({Instr[27:26] == 2'b01 && !Instr[20], Instr[27:26] == 2'b10}));
            chk("m_bytemem", 32'(ByteMem),
                32'(m_state >= 4'd2 && m_state <= 4'd5 && Instr[27:26] == 2'b01 && Instr[22]));
            if (ck_adr) chk("m_adrsrc", 32'(AdrSrc), 32'(e_adr));
            if (ck_rs) chk("m_resultsrc", 32'(ResultSrc), 32'(e_rs));
            if (ck_mux) begin
                chk("m_srca", 32'(ALUSrcA), 32'(e_a));
                chk("m_srcb", 32'(ALUSrcB), 32'(e_b));
                chk("m_aluctl", 32'(ALUControl), 32'(e_alu));
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:12] mk_dp(input logic [3:0] c, input logic i,
                                           input logic [3:0] cmd, input logic s,
                                           input logic [3:0] rd);
        return {c, 2'b00, i, cmd, s, 4'h2, rd};
    endfunction

    function automatic logic [31:12] mk_mem(input logic [3:0] c, input logic u,
                                            input logic b, input logic l,
                                            input logic [3:0] rd);
        return {c, 2'b01, 1'b0, 1'b1, u, b, 1'b0, l, 4'h2, rd};
    endfunction

    function automatic logic [31:12] mk_br(input logic [3:0] c);
        return {c, 2'b10, 2'b10, 12'h004};
    endfunction

    function automatic logic [31:12] rand_instr();
        logic [3:0] cmds [9];
        logic [3:0] c, cmd, rd;
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001,
                 4'b1101, 4'b1010, 4'b0011, 4'b1111};
        c   = ($urandom % 2 == 0) ? 4'hE : 4'($urandom);
        cmd = ($urandom % 5 == 0) ? 4'($urandom) : cmds[$urandom % 9];
        rd  = ($urandom % 4 == 0) ? 4'hF : 4'($urandom);
        return {c, 2'($urandom), 1'($urandom), cmd, 1'($urandom), 4'($urandom), rd};
    endfunction

    task automatic step(input logic r, input logic [3:0] af, input logic [31:12] ins);
        @(negedge clk);
        MemReady = r;
        ALUFlags = af;
        Instr    = ins;
        #1;
    endtask

    logic [31:12] cur;

    initial begin
        reset = 1'b0; MemReady = 1'b0; ALUFlags = 4'h0;
        cur = {4'hE, 2'b11, 14'h0}; Instr = cur;
        #1 reset = 1'b1;
        step(1, 4'h0, cur);
        step(1, 4'h0, cur);
        run_cmp = 1'b1;
        chk("rst_state", 32'(State), 32'd0);
        chk("rst_irwrite", 32'(IRWrite), 32'd0);
        chk("rst_pcwrite", 32'(PCWrite), 32'd0);

        // fetch stall: ready low for three cycles, then high
        step(0, 4'h0, cur); reset = 1'b0;
        chk("stall1_state", 32'(State), 32'd0); chk("stall1_ir", 32'(IRWrite), 32'd0);
        step(0, 4'h0, cur); chk("stall2_ir", 32'(IRWrite), 32'd0);
        step(0, 4'h0, cur); chk("stall3_pc", 32'(PCWrite), 32'd0);
        step(1, 4'h0, cur);
        chk("fetch_ir", 32'(IRWrite), 32'd1); chk("fetch_pc", 32'(PCWrite), 32'd1);
        chk("fetch_state", 32'(State), 32'd0);

        // ADDS R1,R2,R3 with ALU flags Z
        cur = mk_dp(4'hE, 1'b0, 4'b0100, 1'b1, 4'h1);
        step(1, 4'b0100, cur); chk("adds_s1", 32'(State), 32'd1);
        step(1, 4'b0100, cur); chk("adds_s6", 32'(State), 32'd6);
        chk("adds_exec_rw", 32'(RegWrite), 32'd0);
        step(1, 4'b0100, cur); chk("adds_s8", 32'(State), 32'd8);
        chk("adds_rw", 32'(RegWrite), 32'd1); chk("adds_flags", 32'(dut.flags), 32'h4);
        step(1, 4'h0, cur); chk("adds_s0", 32'(State), 32'd0);

        // BEQ taken, BNE not taken
        cur = mk_br(4'h0);
        step(1, 4'h0, cur); chk("beq_s1", 32'(State), 32'd1);
        step(1, 4'h0, cur); chk("beq_s9", 32'(State), 32'd9);
        chk("beq_pc", 32'(PCWrite), 32'd1);
        step(1, 4'h0, cur); chk("beq_s0", 32'(State), 32'd0);
        cur = mk_br(4'h1);
        step(1, 4'h0, cur);
        step(1, 4'h0, cur); chk("bne_s9", 32'(State), 32'd9);
        chk("bne_pc", 32'(PCWrite), 32'd0);
        step(1, 4'h0, cur);

        // STRB with ready delayed two cycles
        cur = mk_mem(4'hE, 1'b1, 1'b1, 1'b0, 4'h3);
        step(1, 4'h0, cur); chk("strb_s1", 32'(State), 32'd1);
        step(0, 4'h0, cur); chk("strb_s2", 32'(State), 32'd2);
        chk("strb_bm2", 32'(ByteMem), 32'd1);
        step(0, 4'h0, cur); chk("strb_s5a", 32'(State), 32'd5);
        chk("strb_mw_a", 32'(MemWrite), 32'd1); chk("strb_adr", 32'(AdrSrc), 32'd1);
        step(0, 4'h0, cur); chk("strb_s5b", 32'(State), 32'd5);
        chk("strb_mw_b", 32'(MemWrite), 32'd1);
        step(1, 4'h0, cur); chk("strb_s5c", 32'(State), 32'd5);
        chk("strb_mw_c", 32'(MemWrite), 32'd1); chk("strb_bm5", 32'(ByteMem), 32'd1);
        step(1, 4'h0, cur); chk("strb_s0", 32'(State), 32'd0);
        chk("strb_mw_off", 32'(MemWrite), 32'd0);

        // LDRNE with Z=1: walks the load path but does not write
        cur = mk_mem(4'h1, 1'b1, 1'b0, 1'b1, 4'h4);
        step(1, 4'h0, cur);
        step(1, 4'h0, cur); chk("ldrne_s2", 32'(State), 32'd2);
        step(1, 4'h0, cur); chk("ldrne_s3", 32'(State), 32'd3);
        step(1, 4'h0, cur); chk("ldrne_s4", 32'(State), 32'd4);
        chk("ldrne_rw", 32'(RegWrite), 32'd0);
        step(1, 4'h0, cur);

        // LDR always, ready late, subtract offset
        cur = mk_mem(4'hE, 1'b0, 1'b0, 1'b1, 4'h5);
        step(1, 4'h0, cur);
        step(0, 4'h0, cur); chk("ldr_sub", 32'(ALUControl), 32'd1);
        step(1, 4'h0, cur); chk("ldr_wait", 32'(State), 32'd3);
        step(1, 4'h0, cur); chk("ldr_s4", 32'(State), 32'd4);
        chk("ldr_rw", 32'(RegWrite), 32'd1); chk("ldr_rs", 32'(ResultSrc), 32'd1);
        step(1, 4'h0, cur);

        // MOV PC, #imm
        cur = mk_dp(4'hE, 1'b1, 4'b1101, 1'b0, 4'hF);
        step(1, 4'h0, cur);
        step(1, 4'h0, cur); chk("mov_s7", 32'(State), 32'd7);
        chk("mov_alu", 32'(ALUControl), 32'd5);
        step(1, 4'h0, cur); chk("mov_pc", 32'(PCWrite), 32'd1);
        chk("mov_rw", 32'(RegWrite), 32'd0);
        step(1, 4'h0, cur);

        // undefined op: straight back to FETCH, no enables
        cur = {4'hE, 2'b11, 14'h0};
        step(1, 4'h0, cur); chk("und_s1", 32'(State), 32'd1);
        step(0, 4'h0, cur); chk("und_s0", 32'(State), 32'd0);
        chk("und_en", 32'({PCWrite, IRWrite, MemWrite, RegWrite}), 32'd0);
        step(1, 4'h0, cur);

        // reset in the middle of a stalled store
        cur = mk_mem(4'hE, 1'b1, 1'b0, 1'b0, 4'h6);
        step(1, 4'h0, cur);
        step(0, 4'h0, cur);
        step(0, 4'h0, cur); chk("rstwr_mw", 32'(MemWrite), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstwr_mw_drop", 32'(MemWrite), 32'd0);
        chk("rstwr_state", 32'(State), 32'd0);
        chk("rstwr_flags", 32'(dut.flags), 32'd0);
        step(0, 4'h0, cur); reset = 1'b0;

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (m_state == 4'd1) Instr = rand_instr();
            MemReady = ($urandom % 3) != 0;
            ALUFlags = 4'($urandom);
            if (reset) reset = 1'b0;
            else if ($urandom % 150 == 0) reset = 1'b1;
        end

        @(negedge clk);
        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multicycle successor to the single-cycle ARM controller.
- A Moore main FSM sequences instruction fetch, decode, execute, memory and writeback over 3–5 cycles.
- Supports a memory-ready handshake for a shared instruction/data memory, plus registered NZCV flags with conditional execution.
- Sits between the multicycle datapath (IR, PC, shared memory, ALU) and the register file.

Parameters:
- ALUCTRL_W, 3: width of ALUControl. Must be ≥3.
- BYTE_EN, 1: when 1, the B bit (Instr[22]) on LDR/STR drives ByteMem. When 0, ByteMem is tied to 0.
- MEM_HANDSHAKE, 1: when 1, memory states wait for MemReady. When 0, MemReady is ignored and treated as 1.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high.
- Instr, input, 20 (bits [31:12]): current IR contents.
- ALUFlags, input, 4: NZCV from the ALU.
- MemReady, input, 1: memory access completes this cycle.
- PCWrite, output, 1: PC register enable.
- AdrSrc, output, 1: memory address select. 0 = PC, 1 = ALUResult register.
- IRWrite, output, 1: IR enable.
- MemWrite, output, 1: memory write strobe.
- ByteMem, output, 1: byte access (LDRB/STRB).
- RegWrite, output, 1: register file write enable.
- ResultSrc, output, 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA, output, 2: ALU operand A select. 00 = Rn, 01 = PC, 10 = ALUOut.
- ALUSrcB, output, 2: ALU operand B select. 00 = Rm, 01 = ExtImm, 10 = constant 4.
- ImmSrc, output, 2: immediate extend type.
- RegSrc, output, 2: register address selects.
- ALUControl, output, ALUCTRL_W: ALU operation.
- State, output, 4: current FSM state encoding, for debug.

Behaviour:
- **States and encoding:** FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10–15 are illegal and go to FETCH.

- **Reset:**
  - Asynchronous; on reset the FSM goes to FETCH and the flag registers (N, Z, C, V) and CondExR clear to 0.
  - While reset is asserted, all write enables are 0: PCWrite, IRWrite, MemWrite, RegWrite.
  - Reset mid-instruction abandons the instruction with no partial writes after assertion.

- **FETCH:**
  - Controls: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10.
  - When MemReady=1: IRWrite=1 and PCWrite=1, go to DECODE.
  - When MemReady=0: stay in FETCH with all enables 0.

- **DECODE:** ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10 (provides PC+8). CondExR latches the condition result from the current flags at the end of this cycle.

- **Next state from DECODE (Op = Instr[27:26]):**
  - Op=01 goes to MEMADR.
  - Op=00 with I=Instr[25]=0 goes to EXECR; with I=1 goes to EXECI.
  - Op=10 goes to BRANCH.
  - Op=11 (undefined) goes to FETCH as a NOP.

- **MEMADR:** ALUSrcA=00, ALUSrcB=01, ADD when U=Instr[23]=1, SUB when U=0. Then L=Instr[20]=1 goes to MEMRD, L=0 goes to MEMWR.

- **MEMRD:** AdrSrc=1. Holds while MemReady=0; goes to MEMWB on MemReady.

- **MEMWB:** ResultSrc=01, RegWrite=CondExR, then FETCH.

- **MEMWR:**
  - AdrSrc=1, MemWrite=CondExR. MemWrite stays asserted until MemReady, then FETCH.
  - If CondExR=0, go straight to FETCH without waiting.

- **EXECR / EXECI:**
  - ALUSrcA=00, ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUControl from cmd=Instr[24:21]: ADD(0100)=000, SUB(0010)=001, AND(0000)=010, ORR(1100)=011, EOR(0001)=100, MOV(1101)=101, CMP(1010)=001.
  - Any other cmd gives 000 with no register write.
  - Then ALUWB.

- **ALUWB:**
  - ResultSrc=00.
  - RegWrite=CondExR, except CMP and unsupported cmds, which give RegWrite=0.
  - If Rd=Instr[15:12]=15 and the write is enabled: PCWrite=1 and RegWrite=0.
  - Then FETCH.

- **BRANCH:** ALUSrcA=00, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondExR, then FETCH.

- **Flags:**
  - Updated only at the end of EXECR/EXECI, only when S=Instr[20]=1 and CondExR=1 (CMP always updates when CondExR=1).
  - N and Z update on every such update. C and V update only for ADD, SUB and CMP.

- **Conditions (cond=Instr[31:28]):** EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL as per ARM. cond=1111 evaluates false.

- **Decoded fields:**
  - ImmSrc = Op. RegSrc[0] = (Op==10). RegSrc[1] = (Op==01 and L=0).
  - ByteMem = BYTE_EN & (Op==01) & Instr[22], asserted in MEMADR through MEMWB/MEMWR; 0 otherwise.

- **Unused width:** ALUControl bits above [2] are 0.

Test Plan:
- **Reset mid-MEMWR:** assert reset in MEMWR with MemReady=0 → MemWrite drops immediately; State=0; flags=0000.
- **Fetch stall:** MemReady=0 for 3 cycles, then 1 → IRWrite/PCWrite pulse once, on the 4th cycle; State 0→0→0→0→1.
- **ADDS then BEQ:**
  - Run ADDS R1,R2,R3 with ALUFlags=0100 → states 0,1,6,8, RegWrite in ALUWB, Z=1.
  - Then BEQ → states 0,1,9, with PCWrite=1 in BRANCH.
- **BNE with Z=1:** BRANCH state has PCWrite=0.
- **STRB, MemReady delayed 2 cycles (BYTE_EN=1):** states 0,1,2,5,5,5,0; MemWrite=1 for 3 cycles; ByteMem=1; AdrSrc=1.
- **Conditional/special cases:**
  - LDR with cond=NE and Z=1 → states 0,1,2,3,4, with RegWrite=0 in MEMWB.
  - MOV to R15 → PCWrite=1 and RegWrite=0 in ALUWB.
  - Op=11 → DECODE→FETCH with no enables.
